serial_add_seq: RTL

- Sequencer that wraps the existing bit-serial adder. It sits directly around it, feeding the adder upstream and consuming its output downstream.
- Accepts two W-bit operands over a valid/ready handshake and shifts them into the adder LSB-first, one bit per clock.
- Collects the adder's sum bits and final carry into a (W+1)-bit parallel result, presented on a valid/ready output.
- Owns the adder's carry-clear, so the testbench-style manual bit indexing is no longer needed.

---
 rtl/serial_add_pkg.sv | 25 ++
 rtl/serial_shift_reg.sv | 35 +++
 rtl/serial_add_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_pkg
//  Brief    : Shared types and helpers for the bit-serial adder sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    // Operand width used when the parent does not override W.
    localparam int SERIAL_ADD_W_DEFAULT = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of a counter that must hold 0..w-1 (at least one bit).
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_shift_reg
//  Brief    : W-bit shift register with parallel load, shift-right and
//             serial (LSB) output.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,      // asynchronous, active-low
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_d,
    output logic         o_ser
);

    logic [W-1:0] r_q;

    // Load has priority over shift; vacated MSBs fill with zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_shift) begin
            r_q <= {1'b0, r_q[W-1:1]};
        end
    end

    assign o_ser = r_q[0];

endmodule
`default_nettype wire

// File: rtl/serial_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_seq
//  Brief    : Sequencer around an external bit-serial adder. Accepts a W-bit
//             operand pair, streams it LSB-first into the adder, collects the
//             W sum bits plus final carry into a (W+1)-bit result.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int W = SERIAL_ADD_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,        // asynchronous, active-low
    // operand side
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    // result side
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   out_sum,
    // adder side
    output logic         add_a,
    output logic         add_b,
    output logic         add_clr,
    input  logic         add_sum,
    input  logic         add_cout,
    // status
    output logic         busy
);

    localparam int CW = cnt_width(W);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_bit_cnt;
    logic [W:0]    r_res;
    logic          w_load;
    logic          w_shift;
    logic          w_last;
    logic          w_a_ser;
    logic          w_b_ser;

    assign w_last = (r_bit_cnt == CW'(W-1));

    serial_shift_reg #(.W(W)) u_sh_a (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_d     (in_a),
        .o_ser   (w_a_ser)
    );

    serial_shift_reg #(.W(W)) u_sh_b (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_d     (in_b),
        .o_ser   (w_b_ser)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake/adder control; the adder carry is held clear
    // in every state except SHIFT so nothing leaks between operations.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_sum     = '0;
        add_clr     = 1'b1;
        add_a       = 1'b0;
        add_b       = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = rst;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                add_clr = 1'b0;
                add_a   = w_a_ser;
                add_b   = w_b_ser;
                w_shift = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_sum   = r_res;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bit counter and result collector: sum bit lands at the current bit
    // position, the final carry lands in the top bit on the last shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt <= '0;
            r_res     <= '0;
        end else if (w_load) begin
            r_bit_cnt <= '0;
            r_res     <= '0;
        end else if (w_shift) begin
            for (int i = 0; i < W; i++) begin
                if (r_bit_cnt == CW'(i)) begin
                    r_res[i] <= add_sum;
                end
            end
            if (w_last) begin
                r_res[W]  <= add_cout;
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire
